// File: rtl/mix_sequencer.sv
// mix_sequencer: programmable microfluidic assay controller.
// Doses each enabled inlet channel in index order, with a fixed settle gap
// between doses, then runs a mix dwell and an outlet flush. Abort jumps
// straight to a full flush. All outputs are registered from the next state.
module mix_sequencer #(
  parameter int unsigned NUM_SOLN = 3,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            start,
  input  logic                                            abort,
  input  logic [NUM_SOLN-1:0]                             chan_en,
  input  logic [NUM_SOLN*CNT_W-1:0]                       dose_len,
  input  logic [CNT_W-1:0]                                mix_len,
  input  logic [CNT_W-1:0]                                flush_len,
  output logic [NUM_SOLN-1:0]                             valve_open,
  output logic                                            pump_on,
  output logic                                            out_valve_open,
  output logic [((NUM_SOLN > 1) ? $clog2(NUM_SOLN) : 1)-1:0] cur_chan,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            aborted
);

  localparam int unsigned CH_W = (NUM_SOLN > 1) ? $clog2(NUM_SOLN) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DOSE  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_MIX   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CH_W-1:0]          chan_q, chan_d;
  logic [NUM_SOLN-1:0]      en_q, en_d;
  logic [NUM_SOLN*CNT_W-1:0] dose_q, dose_d;
  logic [CNT_W-1:0]         mix_q, mix_d;
  logic [CNT_W-1:0]         flush_q, flush_d;

  logic [NUM_SOLN-1:0]      valve_q, valve_d;
  logic                     pump_q, pump_d;
  logic                     outv_q, outv_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     abt_q, abt_d;

  logic                     idle;
  logic [NUM_SOLN-1:0]      en_src;
  logic [NUM_SOLN*CNT_W-1:0] dose_src;
  logic                     nxt_found;
  logic [CH_W-1:0]          nxt_chan;
  logic [CNT_W-1:0]         nxt_len;

  // Zero-length dwell still occupies one cycle.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  assign idle = (state_q == S_IDLE);

  // Next qualifying channel: lowest enabled nonzero-length channel, above the current one once running.
  always_comb begin
    en_src    = idle ? chan_en  : en_q;
    dose_src  = idle ? dose_len : dose_q;
    nxt_found = 1'b0;
    nxt_chan  = '0;
    nxt_len   = '0;
    for (int i = 0; i < int'(NUM_SOLN); i++) begin
      if (!nxt_found && en_src[i] && (dose_src[i*CNT_W +: CNT_W] != '0) &&
          (idle || (CH_W'(i) > chan_q))) begin
        nxt_found = 1'b1;
        nxt_chan  = CH_W'(i);
        nxt_len   = dose_src[i*CNT_W +: CNT_W];
      end
    end
  end

  // Next-state, counter, config latch and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    en_d    = en_q;
    dose_d  = dose_q;
    mix_d   = mix_q;
    flush_d = flush_q;
    abt_d   = abt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          en_d    = chan_en;
          dose_d  = dose_len;
          mix_d   = mix_len;
          flush_d = flush_len;
          abt_d   = 1'b0;
          chan_d  = '0;
          if (nxt_found) begin
            state_d = S_DOSE;
            chan_d  = nxt_chan;
            cnt_d   = nxt_len - CNT_W'(1);
          end else begin
            state_d = S_MIX;
            cnt_d   = len_m1(mix_len);
          end
        end
      end
      S_DOSE: begin
        if (abort) begin
          state_d = S_FLUSH;
          abt_d   = 1'b1;
          cnt_d   = len_m1(flush_q);
        end else if (cnt_q == '0) begin
          if (nxt_found) begin
            state_d = S_GAP;
            cnt_d   = CNT_W'(GAP_CYC - 1);
          end else begin
            state_d = S_MIX;
            cnt_d   = len_m1(mix_q);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_FLUSH;
          abt_d   = 1'b1;
          cnt_d   = len_m1(flush_q);
        end else if (cnt_q == '0) begin
          state_d = S_DOSE;
          chan_d  = nxt_chan;
          cnt_d   = nxt_len - CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_MIX: begin
        if (abort) begin
          state_d = S_FLUSH;
          abt_d   = 1'b1;
          cnt_d   = len_m1(flush_q);
        end else if (cnt_q == '0) begin
          state_d = S_FLUSH;
          cnt_d   = len_m1(flush_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    valve_d = (state_d == S_DOSE) ? (NUM_SOLN'(1) << chan_d) : '0;
    pump_d  = (state_d == S_DOSE) || (state_d == S_GAP) || (state_d == S_FLUSH);
    outv_d  = (state_d == S_FLUSH);
    busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
  end

  // State, counter, config and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      en_q    <= '0;
      dose_q  <= '0;
      mix_q   <= '0;
      flush_q <= '0;
      valve_q <= '0;
      pump_q  <= 1'b0;
      outv_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      en_q    <= en_d;
      dose_q  <= dose_d;
      mix_q   <= mix_d;
      flush_q <= flush_d;
      valve_q <= valve_d;
      pump_q  <= pump_d;
      outv_q  <= outv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  assign valve_open     = valve_q;
  assign pump_on        = pump_q;
  assign out_valve_open = outv_q;
  assign cur_chan       = chan_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = abt_q;

endmodule
